quiz_round_arbiter: RTL and testbench

- Sequences each quiz question: opens a buzz-in window, arbitrates the four player buzzers, times the answer and records the host's judgement.
- Produces the play_count and player1..4_list result vectors that the inspect-question view reads.
- Active only while view == 3 (game view).

---
 rtl/quiz_round_arbiter.sv | 169 ++++++++++++++++
 tb/tb_quiz_round_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_arbiter.sv
// Quiz question sequencer: opens a buzz-in window, arbitrates four players with
// rotating priority, times the answer and records the host's verdict per question.
module quiz_round_arbiter #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int BUZZ_WINDOW = 10,
  parameter int ANSWER_TIME = 5,
  parameter int BEEP_CYCLES = 20_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  view,
  input  logic [4:0]  bt_edge,
  input  logic [3:0]  buzz,
  output logic [3:0]  play_count,
  output logic [17:0] player1_list,
  output logic [17:0] player2_list,
  output logic [17:0] player3_list,
  output logic [17:0] player4_list,
  output logic [1:0]  winner,
  output logic        winner_valid,
  output logic [3:0]  countdown,
  output logic [2:0]  phase,
  output logic        buzzer
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READY  = 3'd1;
  localparam logic [2:0] ANSWER = 3'd2;
  localparam logic [2:0] RESULT = 3'd3;
  localparam logic [2:0] FULL   = 3'd4;

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [DIV_W-1:0]  div;
  logic [BEEP_W-1:0] beep_cnt;
  logic [1:0]        ptr;
  logic [17:0]       lists [4];
  logic              active;
  logic              tick;
  logic              last_second;
  logic [1:0]        pick;
  logic [1:0]        cand;
  logic              found;
  logic [1:0]        ans_code;
  logic              ans_done;
  logic [4:0]        slot;
  logic              unused_bits;

  assign active       = (view == 3'd3);
  assign tick         = (div == DIV_W'(TICK_DIV - 1));
  assign last_second  = tick && (countdown <= 4'd1);
  assign slot         = {play_count, 1'b0};
  assign buzzer       = (beep_cnt != '0);
  assign unused_bits  = bt_edge[3];
  assign player1_list = lists[0];
  assign player2_list = lists[1];
  assign player3_list = lists[2];
  assign player4_list = lists[3];

  // Rotating priority: scan from the pointer, wrapping p4 -> p1.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && buzz[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // A verdict beats an expiring timer; "correct" beats "wrong".
  always_comb begin
    ans_code = 2'b11;
    if (bt_edge[0])      ans_code = 2'b01;
    else if (bt_edge[1]) ans_code = 2'b10;
    ans_done = bt_edge[0] || bt_edge[1] || last_second;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div          <= '0;
      beep_cnt     <= '0;
      ptr          <= 2'd0;
      play_count   <= 4'd0;
      winner       <= 2'd0;
      winner_valid <= 1'b0;
      countdown    <= 4'd0;
      phase        <= IDLE;
      for (int i = 0; i < 4; i++) lists[i] <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (beep_cnt != '0) beep_cnt <= beep_cnt - BEEP_W'(1);

      if (!active) begin
        if (phase == READY || phase == ANSWER) begin
          phase        <= IDLE;
          winner_valid <= 1'b0;
          countdown    <= 4'd0;
          beep_cnt     <= '0;
          div          <= '0;
        end
      end else if (bt_edge[4]) begin
        for (int i = 0; i < 4; i++) lists[i] <= '0;
        play_count   <= 4'd0;
        ptr          <= 2'd0;
        winner       <= 2'd0;
        winner_valid <= 1'b0;
        countdown    <= 4'd0;
        phase        <= IDLE;
        div          <= '0;
      end else begin
        case (phase)
          IDLE: if (bt_edge[2]) begin
            div <= '0;
            if (play_count < 4'd9) begin
              phase     <= READY;
              countdown <= 4'(BUZZ_WINDOW);
            end else begin
              phase <= FULL;
            end
          end
          READY: if (|buzz) begin
            phase        <= ANSWER;
            winner       <= pick;
            winner_valid <= 1'b1;
            countdown    <= 4'(ANSWER_TIME);
            beep_cnt     <= BEEP_W'(BEEP_CYCLES);
            div          <= '0;
          end else if (last_second) begin
            for (int i = 0; i < 4; i++) lists[i][slot +: 2] <= 2'b00;
            countdown  <= 4'd0;
            play_count <= play_count + 4'd1;
            phase      <= RESULT;
            beep_cnt   <= BEEP_W'(BEEP_CYCLES);
            div        <= '0;
          end else if (tick) begin
            countdown <= countdown - 4'd1;
          end
          ANSWER: if (ans_done) begin
            lists[winner][slot +: 2] <= ans_code;
            ptr        <= winner + 2'd1;
            countdown  <= 4'd0;
            play_count <= play_count + 4'd1;
            phase      <= RESULT;
            div        <= '0;
          end else if (tick) begin
            countdown <= countdown - 4'd1;
          end
          RESULT: if (bt_edge[2]) begin
            winner_valid <= 1'b0;
            div          <= '0;
            if (play_count < 4'd9) begin
              phase     <= READY;
              countdown <= 4'(BUZZ_WINDOW);
            end else begin
              phase <= FULL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Bench for quiz_round_arbiter: directed scenarios plus a randomized run
// compared against a question-level reference model.
module tb_quiz_round_arbiter;

  localparam int TD = 4;
  localparam int BW = 3;
  localparam int AT = 2;
  localparam int BC = 3;

  logic        clk;
  logic        rst;
  logic [2:0]  view;
  logic [4:0]  bt_edge;
  logic [3:0]  buzz;
  logic [3:0]  play_count;
  logic [17:0] player1_list, player2_list, player3_list, player4_list;
  logic [1:0]  winner;
  logic        winner_valid;
  logic [3:0]  countdown;
  logic [2:0]  phase;
  logic        buzzer;

  int total = 0;
  int bad   = 0;

  quiz_round_arbiter #(
    .TICK_DIV(TD), .BUZZ_WINDOW(BW), .ANSWER_TIME(AT), .BEEP_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst), .view(view), .bt_edge(bt_edge), .buzz(buzz),
    .play_count(play_count),
    .player1_list(player1_list), .player2_list(player2_list),
    .player3_list(player3_list), .player4_list(player4_list),
    .winner(winner), .winner_valid(winner_valid), .countdown(countdown),
    .phase(phase), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one result code per player per question, seconds-based timers.
  int         m_phase, m_pc, m_ptr, m_win, m_wv, m_cd, m_beep, m_cyc;
  logic [1:0] m_list [4][9];

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_ptr = 0; m_win = 0; m_wv = 0; m_cd = 0; m_beep = 0; m_cyc = 0;
    for (int p = 0; p < 4; p++) for (int q = 0; q < 9; q++) m_list[p][q] = 2'b00;
  endtask

  task automatic model_edge(input logic [2:0] v, input logic [4:0] b, input logic [3:0] z);
    bit entered = 0;
    bit tk = ((m_cyc + 1) % TD) == 0;
    int code = 0;
    if (m_beep > 0) m_beep--;
    if (v != 3) begin
      if (m_phase == 1 || m_phase == 2) begin
        m_phase = 0; m_wv = 0; m_cd = 0; m_beep = 0; entered = 1;
      end
    end else if (b[4]) begin
      for (int p = 0; p < 4; p++) for (int q = 0; q < 9; q++) m_list[p][q] = 2'b00;
      m_pc = 0; m_ptr = 0; m_win = 0; m_wv = 0; m_cd = 0; m_phase = 0; entered = 1;
    end else begin
      case (m_phase)
        0: if (b[2]) begin
          entered = 1;
          if (m_pc < 9) begin m_phase = 1; m_cd = BW; end else m_phase = 4;
        end
        1: if (z != 0) begin
          for (int i = 3; i >= 0; i--) if (z[(m_ptr + i) % 4]) m_win = (m_ptr + i) % 4;
          m_phase = 2; m_wv = 1; m_cd = AT; m_beep = BC; entered = 1;
        end else if (tk) begin
          if (m_cd == 1) begin
            m_cd = 0; m_pc++; m_phase = 3; m_beep = BC; entered = 1;
          end else m_cd--;
        end
        2: begin
          if (b[0]) code = 1;
          else if (b[1]) code = 2;
          else if (tk && m_cd == 1) code = 3;
          if (code != 0) begin
            m_list[m_win][m_pc] = 2'(code);
            m_ptr = (m_win + 1) % 4; m_pc++; m_cd = 0; m_phase = 3; entered = 1;
          end else if (tk) m_cd--;
        end
        3: if (b[2]) begin
          m_wv = 0; entered = 1;
          if (m_pc < 9) begin m_phase = 1; m_cd = BW; end else m_phase = 4;
        end
        default: ;
      endcase
    end
    m_cyc = entered ? 0 : m_cyc + 1;
  endtask

  function automatic logic [17:0] exp_list(input int p);
    logic [17:0] v = '0;
    for (int q = 0; q < 9; q++) v[2*q +: 2] = m_list[p][q];
    return v;
  endfunction

  // Inputs are applied just after an edge, held through the next edge, then pulses drop.
  task automatic step(input logic [2:0] v, input logic [4:0] b, input logic [3:0] z);
    view = v; bt_edge = b; buzz = z;
    @(posedge clk);
    model_edge(v, b, z);
    #1;
    bt_edge = '0; buzz = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; view = 3'd3; bt_edge = '0; buzz = '0;
    model_reset();
    #2;
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    total++; if (play_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", play_count); end
    total++; if ({player1_list, player2_list, player3_list, player4_list} !== 72'd0) begin
      bad++; $display("FAIL reset_lists got=%h exp=0", {player1_list, player2_list, player3_list, player4_list}); end
    total++; if ({winner, winner_valid, countdown, buzzer} !== 8'd0) begin
      bad++; $display("FAIL reset_misc got=%h exp=0", {winner, winner_valid, countdown, buzzer}); end
    #10 rst = 1'b1;
    @(posedge clk); model_edge(3'd3, 5'd0, 4'd0); #1;
  endtask

  task automatic test_buzz_correct();
    step(3'd3, 5'b00100, 4'b0000);
    total++; if (phase !== 3'd1 || countdown !== 4'd3) begin
      bad++; $display("FAIL start_ready got=%0d/%0d exp=1/3", phase, countdown); end
    step(3'd3, 5'b00000, 4'b0100);
    total++; if (phase !== 3'd2 || winner !== 2'd2 || winner_valid !== 1'b1) begin
      bad++; $display("FAIL buzz_lock got=%0d/%0d/%0d exp=2/2/1", phase, winner, winner_valid); end
    total++; if (countdown !== 4'd2) begin bad++; $display("FAIL answer_cd got=%0d exp=2", countdown); end
    for (int i = 0; i < 3; i++) begin
      total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL beep_on cycle=%0d got=%b exp=1", i, buzzer); end
      step(3'd3, 5'b00000, 4'b0000);
    end
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL beep_off got=%b exp=0", buzzer); end
    step(3'd3, 5'b00001, 4'b0000);
    total++; if (player3_list !== 18'h00001 || play_count !== 4'd1 || phase !== 3'd3) begin
      bad++; $display("FAIL judge_correct got=%h/%0d/%0d exp=00001/1/3", player3_list, play_count, phase); end
  endtask

  task automatic test_rotation_timeout();
    step(3'd3, 5'b00100, 4'b0000);
    step(3'd3, 5'b00000, 4'b1111);
    total++; if (winner !== 2'd3) begin bad++; $display("FAIL rotate_p4 got=%0d exp=3", winner); end
    for (int i = 0; i < 7; i++) step(3'd3, 5'b00000, 4'b0000);
    total++; if (phase !== 3'd2 || countdown !== 4'd1) begin
      bad++; $display("FAIL answer_wait got=%0d/%0d exp=2/1", phase, countdown); end
    step(3'd3, 5'b00000, 4'b0000);
    total++; if (player4_list !== 18'h0000C || play_count !== 4'd2 || phase !== 3'd3) begin
      bad++; $display("FAIL answer_timeout got=%h/%0d/%0d exp=0000c/2/3", player4_list, play_count, phase); end
  endtask

  task automatic test_no_buzz();
    step(3'd3, 5'b00100, 4'b0000);
    for (int i = 0; i < 4; i++) step(3'd3, 5'b00000, 4'b0000);
    total++; if (countdown !== 4'd2) begin bad++; $display("FAIL window_cd got=%0d exp=2", countdown); end
    for (int i = 0; i < 7; i++) step(3'd3, 5'b00000, 4'b0000);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL window_open got=%0d exp=1", phase); end
    step(3'd3, 5'b00000, 4'b0000);
    total++; if (phase !== 3'd3 || countdown !== 4'd0 || play_count !== 4'd3) begin
      bad++; $display("FAIL window_expire got=%0d/%0d/%0d exp=3/0/3", phase, countdown, play_count); end
    total++; if ({player1_list, player2_list, player3_list, player4_list} !== {18'h0, 18'h0, 18'h00001, 18'h0000C}) begin
      bad++; $display("FAIL no_answer_lists got=%h/%h/%h/%h exp=0/0/1/c", player1_list, player2_list, player3_list, player4_list); end
    total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL expire_beep got=%b exp=1", buzzer); end
  endtask

  task automatic test_judge_vs_tick();
    step(3'd3, 5'b00100, 4'b0000);
    step(3'd3, 5'b00000, 4'b1111);
    total++; if (winner !== 2'd0) begin bad++; $display("FAIL ptr_after_noanswer got=%0d exp=0", winner); end
    for (int i = 0; i < 7; i++) step(3'd3, 5'b00000, 4'b0000);
    step(3'd3, 5'b00010, 4'b0000);
    total++; if (player1_list !== 18'h00080 || play_count !== 4'd4) begin
      bad++; $display("FAIL judge_beats_tick got=%h/%0d exp=00080/4", player1_list, play_count); end
  endtask

  task automatic test_full_and_clear();
    for (int q = 0; q < 5; q++) begin
      step(3'd3, 5'b00100, 4'b0000);
      step(3'd3, 5'b00000, 4'(1 << $urandom_range(0, 3)));
      step(3'd3, ($urandom_range(0, 1) == 1) ? 5'b00001 : 5'b00010, 4'b0000);
    end
    total++; if (play_count !== 4'd9) begin bad++; $display("FAIL nine_played got=%0d exp=9", play_count); end
    total++; if ({player1_list, player2_list, player3_list, player4_list} !== {exp_list(0), exp_list(1), exp_list(2), exp_list(3)}) begin
      bad++; $display("FAIL nine_lists got=%h/%h/%h/%h exp=%h/%h/%h/%h", player1_list, player2_list, player3_list, player4_list,
                      exp_list(0), exp_list(1), exp_list(2), exp_list(3)); end
    step(3'd3, 5'b00100, 4'b0000);
    total++; if (phase !== 3'd4) begin bad++; $display("FAIL enter_full got=%0d exp=4", phase); end
    step(3'd3, 5'b00111, 4'b1111);
    total++; if (phase !== 3'd4 || play_count !== 4'd9) begin
      bad++; $display("FAIL full_ignores got=%0d/%0d exp=4/9", phase, play_count); end
    step(3'd3, 5'b10000, 4'b0000);
    total++; if (phase !== 3'd0 || play_count !== 4'd0 ||
                 {player1_list, player2_list, player3_list, player4_list} !== 72'd0) begin
      bad++; $display("FAIL clear got=%0d/%0d exp=0/0", phase, play_count); end
  endtask

  task automatic test_view_abort();
    step(3'd3, 5'b00100, 4'b0000);
    step(3'd3, 5'b00000, 4'b0001);
    total++; if (phase !== 3'd2) begin bad++; $display("FAIL abort_setup got=%0d exp=2", phase); end
    step(3'd4, 5'b00000, 4'b0000);
    total++; if (phase !== 3'd0 || play_count !== 4'd0 || buzzer !== 1'b0 || winner_valid !== 1'b0) begin
      bad++; $display("FAIL view_abort got=%0d/%0d/%b/%b exp=0/0/0/0", phase, play_count, buzzer, winner_valid); end
    step(3'd4, 5'b00100, 4'b0000);
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL view_ignored got=%0d exp=0", phase); end
  endtask

  task automatic test_async_reset();
    step(3'd3, 5'b00100, 4'b0000);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL ar_setup got=%0d exp=1", phase); end
    #3 rst = 1'b0;
    #1;
    model_reset();
    total++; if (phase !== 3'd0 || countdown !== 4'd0 || play_count !== 4'd0) begin
      bad++; $display("FAIL async_reset got=%0d/%0d/%0d exp=0/0/0", phase, countdown, play_count); end
    #2 rst = 1'b1;
    step(3'd3, 5'b00000, 4'b0000);
  endtask

  task automatic test_random();
    logic [4:0] b;
    logic [3:0] z;
    logic [2:0] v;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      b = '0;
      b[0] = ($urandom_range(0, 7) == 0);
      b[1] = ($urandom_range(0, 7) == 0);
      b[2] = ($urandom_range(0, 4) == 0);
      b[3] = 1'($urandom_range(0, 1));
      b[4] = ($urandom_range(0, 199) == 0);
      z = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step(v, b, z);
      total++; if (phase !== 3'(m_phase) || play_count !== 4'(m_pc) || countdown !== 4'(m_cd)) begin
        bad++; $display("FAIL rnd_state n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, phase, play_count, countdown, m_phase, m_pc, m_cd); end
      total++; if (winner !== 2'(m_win) || winner_valid !== 1'(m_wv) || buzzer !== (m_beep > 0)) begin
        bad++; $display("FAIL rnd_winner n=%0d got=%0d/%b/%b exp=%0d/%0d/%0d", n, winner, winner_valid, buzzer, m_win, m_wv, m_beep > 0); end
      total++; if ({player1_list, player2_list, player3_list, player4_list} !== {exp_list(0), exp_list(1), exp_list(2), exp_list(3)}) begin
        bad++; $display("FAIL rnd_lists n=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", n, player1_list, player2_list, player3_list, player4_list,
                        exp_list(0), exp_list(1), exp_list(2), exp_list(3)); end
    end
  endtask

  initial begin
    test_reset();
    test_buzz_correct();
    test_rotation_timeout();
    test_no_buzz();
    test_judge_vs_tick();
    test_full_and_clear();
    test_view_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
